echo_delay_responder: RTL and testbench

- Downstream consumer of the echo path's 32-bit request FIFO.
- Dequeues one word at a time and holds it for a programmable number of cycles.
- Then delivers the word to the indication side through a guarded-method handshake (ENA/RDY).
- Also keeps a running count of delivered words for software/debug readback.

---
 rtl/echo_delay_responder_if.sv | 31 +++
 rtl/echo_delay_responder.sv | 81 ++++++++
 tb/tb_echo_delay_responder.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/echo_delay_responder_if.sv
// Handshake bundle between the echo request FIFO, the indication sink, the
// config writer and echo_delay_responder.
interface echo_delay_responder_if #(
   parameter int WIDTH       = 32,
   parameter int DELAY_WIDTH = 8
);
   logic [WIDTH-1:0]       out_first;
   logic                   out_first__RDY;
   logic                   out_deq__RDY;
   logic                   out_deq__ENA;
   logic                   ind_heard__ENA;
   logic [WIDTH-1:0]       ind_heard_v;
   logic                   ind_heard__RDY;
   logic                   cfg_setDelay__ENA;
   logic [DELAY_WIDTH-1:0] cfg_setDelay_v;
   logic                   cfg_setDelay__RDY;

   // Responder side
   modport slave (
      input  out_first, out_first__RDY, out_deq__RDY, ind_heard__RDY,
             cfg_setDelay__ENA, cfg_setDelay_v,
      output out_deq__ENA, ind_heard__ENA, ind_heard_v, cfg_setDelay__RDY
   );

   // Environment side (FIFO, sink, config writer)
   modport master (
      output out_first, out_first__RDY, out_deq__RDY, ind_heard__RDY,
             cfg_setDelay__ENA, cfg_setDelay_v,
      input  out_deq__ENA, ind_heard__ENA, ind_heard_v, cfg_setDelay__RDY
   );
endinterface

// File: rtl/echo_delay_responder.sv
// Dequeues one FIFO word, holds it for a programmable delay, then delivers it
// on the indication method; counts delivered words.
module echo_delay_responder #(
   parameter int WIDTH         = 32,
   parameter int DELAY_WIDTH   = 8,
   parameter int DEFAULT_DELAY = 0,
   parameter int COUNT_WIDTH   = 16
) (
   input  logic                   CLK,
   input  logic                   nRST,
   echo_delay_responder_if.slave  bus,
   output logic [COUNT_WIDTH-1:0] stat_count
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_SEND = 2'd2;

   logic [1:0]             state_q, state_d;
   logic [WIDTH-1:0]       data_q, data_d;
   logic [DELAY_WIDTH-1:0] cnt_q, cnt_d;
   logic [DELAY_WIDTH-1:0] delay_q, delay_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic                   deq_fire, ind_fire, cfg_fire;

   // Dequeue is gated by reset so the FIFO never loses a word while held in reset.
   assign deq_fire = nRST && (state_q == S_IDLE) && bus.out_first__RDY && bus.out_deq__RDY;
   assign ind_fire = (state_q == S_SEND) && bus.ind_heard__RDY;
   assign cfg_fire = bus.cfg_setDelay__ENA && bus.cfg_setDelay__RDY;

   assign bus.out_deq__ENA      = deq_fire;
   assign bus.ind_heard__ENA    = ind_fire;
   assign bus.ind_heard_v       = data_q;
   assign bus.cfg_setDelay__RDY = (state_q == S_IDLE);
   assign stat_count            = count_q;

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      delay_d = delay_q;
      count_d = count_q;
      case (state_q)
         S_IDLE: begin
            if (deq_fire) begin
               data_d  = bus.out_first;
               cnt_d   = delay_q;
               state_d = (delay_q != '0) ? S_WAIT : S_SEND;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - DELAY_WIDTH'(1);
            if (cnt_q == DELAY_WIDTH'(1)) state_d = S_SEND;
         end
         S_SEND: begin
            if (ind_fire) begin
               count_d = count_q + COUNT_WIDTH'(1);
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // A write racing a dequeue lands here, after the word already sampled delay_q.
      if (cfg_fire) delay_d = bus.cfg_setDelay_v;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= S_IDLE;
         data_q  <= '0;
         cnt_q   <= '0;
         delay_q <= DELAY_WIDTH'(DEFAULT_DELAY);
         count_q <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         delay_q <= delay_d;
         count_q <= count_d;
      end
   end
endmodule

// File: tb/tb_echo_delay_responder.sv
// Directed bench: stimulus pushes expected (data, delivery cycle) into a
// scoreboard, a forked monitor pops and compares on every indication strobe.
module tb_echo_delay_responder;
   localparam int W  = 32;
   localparam int DW = 8;
   localparam int CW = 3;   // narrow counter so wraparound is reachable

   logic          CLK  = 1'b0;
   logic          nRST = 1'b0;
   logic [CW-1:0] stat_count;
   int            cyc  = 0;

   echo_delay_responder_if #(.WIDTH(W), .DELAY_WIDTH(DW)) bus ();

   echo_delay_responder #(
      .WIDTH(W), .DELAY_WIDTH(DW), .DEFAULT_DELAY(0), .COUNT_WIDTH(CW)
   ) dut (
      .CLK(CLK), .nRST(nRST), .bus(bus), .stat_count(stat_count)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] data;
      int           at;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_vec = 0;
   int   n_err = 0;
   int   last_deq = 0;
   int   c1 = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic deq_word(input logic [W-1:0] d, input int dly, input int extra, input bit expect_ind);
      int t;
      @(posedge CLK); #1;
      bus.out_first      = d;
      bus.out_first__RDY = 1'b1;
      bus.out_deq__RDY   = 1'b1;
      t = 0;
      @(negedge CLK);
      while (bus.out_deq__ENA !== 1'b1 && t < 400) begin
         @(negedge CLK);
         t++;
      end
      if (bus.out_deq__ENA !== 1'b1) begin
         n_vec++;
         n_err++;
         $display("FAIL deq_timeout: no dequeue of %0h", d);
      end else if (expect_ind) begin
         sb.push_back('{d, cyc + 1 + dly + extra});
      end
      last_deq = cyc;
      @(posedge CLK); #1;
      bus.out_first__RDY = 1'b0;
      bus.out_deq__RDY   = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 400) begin
         @(posedge CLK);
         t++;
      end
      if (sb.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL drain_timeout: %0d deliveries outstanding", sb.size());
         sb.delete();
      end
      @(negedge CLK);
   endtask

   task automatic set_delay(input logic [DW-1:0] v);
      @(posedge CLK); #1;
      bus.cfg_setDelay__ENA = 1'b1;
      bus.cfg_setDelay_v    = v;
      @(negedge CLK);
      chk("cfg_rdy_idle", bus.cfg_setDelay__RDY, 1);
      @(posedge CLK); #1;
      bus.cfg_setDelay__ENA = 1'b0;
   endtask

   initial begin
      bus.out_first         = '0;
      bus.out_first__RDY    = 1'b1;
      bus.out_deq__RDY      = 1'b1;
      bus.ind_heard__RDY    = 1'b1;
      bus.cfg_setDelay__ENA = 1'b0;
      bus.cfg_setDelay_v    = '0;

      fork
         forever begin
            @(negedge CLK);
            if (bus.ind_heard__ENA === 1'b1) begin
               if (sb.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL spurious_ind: data %0h at cycle %0d", bus.ind_heard_v, cyc);
               end else begin
                  e = sb.pop_front();
                  chk("ind_data", bus.ind_heard_v, e.data);
                  chk("ind_cycle", cyc, e.at);
               end
            end
         end
         begin
            #100000;
            $display("FAIL watchdog: simulation did not finish");
            $fatal(1, "watchdog");
         end
      join_none

      // Reset values, with the FIFO offering a word that must not be taken
      repeat (2) @(negedge CLK);
      chk("rst_deq_ena", bus.out_deq__ENA, 0);
      chk("rst_ind_ena", bus.ind_heard__ENA, 0);
      chk("rst_ind_v", bus.ind_heard_v, 0);
      chk("rst_cfg_rdy", bus.cfg_setDelay__RDY, 1);
      chk("rst_stat", stat_count, 0);
      @(posedge CLK); #1;
      nRST = 1'b1;
      bus.out_first__RDY = 1'b0;
      bus.out_deq__RDY   = 1'b0;

      // D=0: delivery the cycle after dequeue
      deq_word(32'hDEADBEEF, 0, 0, 1);
      drain();
      chk("stat_after_1", stat_count, 1);

      // D=3: delivery at t+4, config blocked from t+1 through the firing cycle
      set_delay(8'd3);
      deq_word(32'h00000005, 3, 0, 1);
      repeat (4) begin
         @(negedge CLK);
         chk("cfg_rdy_busy", bus.cfg_setDelay__RDY, 0);
      end
      @(negedge CLK);
      chk("cfg_rdy_back", bus.cfg_setDelay__RDY, 1);
      drain();
      chk("stat_after_2", stat_count, 2);

      // Sink stalls 10 cycles in SEND with another word waiting in the FIFO
      set_delay(8'd0);
      bus.ind_heard__RDY = 1'b0;
      deq_word(32'hA5A55A5A, 0, 10, 1);
      bus.out_first      = 32'h00000077;
      bus.out_first__RDY = 1'b1;
      bus.out_deq__RDY   = 1'b1;
      repeat (10) begin
         @(negedge CLK);
         chk("hold_ind_ena", bus.ind_heard__ENA, 0);
         chk("hold_ind_v", bus.ind_heard_v, 32'hA5A55A5A);
         chk("hold_deq_ena", bus.out_deq__ENA, 0);
      end
      @(posedge CLK); #1;
      bus.ind_heard__RDY = 1'b1;
      bus.out_first__RDY = 1'b0;
      bus.out_deq__RDY   = 1'b0;
      drain();
      chk("stat_after_hold", stat_count, 3);

      // Write of 7 racing a dequeue under delay 2: this word waits 2, next waits 7
      set_delay(8'd2);
      @(posedge CLK); #1;
      bus.out_first         = 32'h00000011;
      bus.out_first__RDY    = 1'b1;
      bus.out_deq__RDY      = 1'b1;
      bus.cfg_setDelay__ENA = 1'b1;
      bus.cfg_setDelay_v    = 8'd7;
      @(negedge CLK);
      chk("race_deq_ena", bus.out_deq__ENA, 1);
      chk("race_cfg_rdy", bus.cfg_setDelay__RDY, 1);
      sb.push_back('{32'h00000011, cyc + 3});
      @(posedge CLK); #1;
      bus.out_first__RDY    = 1'b0;
      bus.out_deq__RDY      = 1'b0;
      bus.cfg_setDelay__ENA = 1'b0;
      drain();
      chk("stat_after_race", stat_count, 4);
      deq_word(32'h00000022, 7, 0, 1);
      drain();
      chk("stat_after_d7", stat_count, 5);

      // Back-to-back stream with D=0, dequeues 2 cycles apart; count 5+3 wraps to 0
      set_delay(8'd0);
      deq_word(32'h1, 0, 0, 1);
      c1 = last_deq;
      deq_word(32'h2, 0, 0, 1);
      chk("stream_gap_2", last_deq, c1 + 2);
      deq_word(32'h3, 0, 0, 1);
      chk("stream_gap_3", last_deq, c1 + 4);
      drain();
      chk("stat_wrap", stat_count, 0);

      // Maximum delay counts out exactly
      set_delay(8'd255);
      deq_word(32'h00000044, 255, 0, 1);
      drain();
      chk("stat_after_d255", stat_count, 1);

      // Asynchronous reset mid-WAIT drops the word and restores delay 0
      set_delay(8'd5);
      deq_word(32'h00000055, 5, 0, 0);
      @(negedge CLK);
      #2;
      bus.out_first__RDY = 1'b1;
      bus.out_deq__RDY   = 1'b1;
      nRST = 1'b0;
      #1;
      chk("arst_ind_v", bus.ind_heard_v, 0);
      chk("arst_ind_ena", bus.ind_heard__ENA, 0);
      chk("arst_cfg_rdy", bus.cfg_setDelay__RDY, 1);
      chk("arst_stat", stat_count, 0);
      chk("arst_deq_ena", bus.out_deq__ENA, 0);
      repeat (2) @(posedge CLK);
      #1;
      nRST = 1'b1;
      bus.out_first__RDY = 1'b0;
      bus.out_deq__RDY   = 1'b0;
      repeat (8) @(posedge CLK);
      deq_word(32'h00000066, 0, 0, 1);
      drain();
      chk("stat_after_arst", stat_count, 1);

      repeat (2) @(negedge CLK);
      chk("sb_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
